// File: rtl/fifo_rd_stream.sv
// Adapts a 1-cycle-latency sync FIFO read port to a valid/ready stream through a 3-entry prefetch buffer.
// Optional FIFO_RD_STREAM_BEAT_CNT_EN adds beat_cnt_o, a free-running count of accepted beats.
module fifo_rd_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       occ_o
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  ,
  output logic [31:0]      beat_cnt_o
`endif
);

  localparam int BUF_DEPTH = 3;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic [1:0]       head;
  logic [1:0]       tail;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] store [BUF_DEPTH];

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign push      = inflight;
  assign pop       = m_valid_o && m_ready_i;
  assign m_valid_o = (state != S0);
  assign m_data_o  = m_valid_o ? store[head] : '0;
  assign occ_o     = state;

  // Only request when the word already in flight still leaves a free slot,
  // so no downstream-ready path is needed and a push can never hit S3.
  assign fifo_rd_en_o = !fifo_empty_i &&
                        (({1'b0, occ_o} + {2'b00, inflight}) <= 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      S0: if (push) state_nxt = S1;
      S1: begin
        if (push && !pop)      state_nxt = S2;
        else if (!push && pop) state_nxt = S0;
      end
      S2: begin
        if (push && !pop)      state_nxt = S3;
        else if (!push && pop) state_nxt = S1;
      end
      S3: if (pop && !push) state_nxt = S2;
      default: state_nxt = S0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= S0;
      inflight <= 1'b0;
      head     <= 2'd0;
      tail     <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en_o;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
    end
  end

  // Storage is not reset; the in-flight word is dropped during reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) store[tail] <= fifo_rdata_i;
  end

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  logic [31:0] beat_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  beat_cnt <= 32'd0;
    else if (pop)  beat_cnt <= beat_cnt + 32'd1;
  end

  assign beat_cnt_o = beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized bench for fifo_rd_stream; the upstream FIFO returns 0xA0 + n for the n-th read.
module tb_fifo_rd_stream;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [1:0]       occ;
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  logic [31:0]      beat_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int unsigned rd_idx = 0;
  int unsigned exp_idx = 0;
  logic        last_rd = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .fifo_rdata_i (fifo_rdata),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .occ_o        (occ)
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    ,
    .beat_cnt_o   (beat_cnt)
`endif
  );

  // Upstream sync FIFO: data valid the cycle after an accepted read, zero otherwise.
  always @(posedge clk) begin
    last_rd <= fifo_rd_en;
    if (fifo_rd_en) begin
      fifo_rdata <= 32'hA0 + rd_idx;
      rd_idx     <= rd_idx + 1;
    end else begin
      fifo_rdata <= '0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d want=0", occ); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", m_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    rst_n = 1'b1; fifo_empty = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stream_rd_en k=%0d got=%b want=1", k, fifo_rd_en); end
      if (k < 2) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_lat_valid k=%0d got=%b want=0", k, m_valid); end
      end else begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%b want=1", k, m_valid); end
        checks++; if (m_data !== 32'hA0 + (k - 2)) begin errors++; $display("FAIL stream_data k=%0d got=%h want=%h", k, m_data, 32'hA0 + (k - 2)); end
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL stream_occ k=%0d got=%0d want=1", k, occ); end
      end
      if (m_valid && m_ready) exp_idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] first;
    first = 32'hA0 + exp_idx;
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || m_data !== first) begin errors++; $display("FAIL bp_hold k=%0d got=%b/%h want=1/%h", k, m_valid, m_data, first); end
      if (k >= 2) begin
        checks++; if (occ !== 2'd3) begin errors++; $display("FAIL bp_occ k=%0d got=%0d want=3", k, occ); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en k=%0d got=%b want=0", k, fifo_rd_en); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_release();
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rel_valid k=%0d got=%b want=1", k, m_valid); end
      checks++; if (m_data !== 32'hA0 + exp_idx) begin errors++; $display("FAIL rel_data k=%0d got=%h want=%h", k, m_data, 32'hA0 + exp_idx); end
      if (m_valid && m_ready) exp_idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    checks++; if (occ !== 2'd1 || last_rd !== 1'b1) begin errors++; $display("FAIL midop_steady got=%0d/%b want=1/1", occ, last_rd); end
    if (m_valid && m_ready) exp_idx++;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (occ !== 2'd2 || last_rd !== 1'b1) begin errors++; $display("FAIL midop_pre got=%0d/%b want=2/1", occ, last_rd); end
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1'b1;
    exp_idx = rd_idx;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL midop_occ got=%0d want=0", occ); end
      end
      if (k < 2) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midop_valid k=%0d got=%b want=0", k, m_valid); end
      end else begin
        checks++; if (m_valid !== 1'b1 || m_data !== 32'hA0 + exp_idx) begin errors++; $display("FAIL midop_data k=%0d got=%b/%h want=1/%h", k, m_valid, m_data, 32'hA0 + exp_idx); end
      end
      if (m_valid && m_ready) exp_idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10006; k++) begin
      if (k < 10000) begin
        fifo_empty = ($urandom_range(0, 3) == 0);
        m_ready    = ($urandom_range(0, 2) != 0);
      end else begin
        fifo_empty = 1'b1;
        m_ready    = 1'b1;
      end
      @(negedge clk);
      checks++; if (last_rd && occ == 2'd3) begin errors++; $display("FAIL rand_push_s3 k=%0d got=push want=none", k); end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 32'hA0 + exp_idx) begin errors++; $display("FAIL rand_data k=%0d got=%h want=%h", k, m_data, 32'hA0 + exp_idx); end
        exp_idx++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (exp_idx !== rd_idx) begin errors++; $display("FAIL rand_count got=%0d want=%0d", exp_idx, rd_idx); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_drained got=%b want=0", m_valid); end
    @(posedge clk); #1;
  endtask

`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
  task automatic test_beat_cnt();
    int pops;
    pops = 0;
    rst_n = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; fifo_empty = 1'b0; m_ready = 1'b1;
    exp_idx = rd_idx;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL beat_reset got=%0d want=0", beat_cnt); end
      end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 32'hA0 + exp_idx) begin errors++; $display("FAIL beat_data got=%h want=%h", m_data, 32'hA0 + exp_idx); end
        exp_idx++;
        pops++;
      end
      @(posedge clk); #1;
      if (pops == 5) begin
        m_ready = 1'b0;
        break;
      end
    end
    @(negedge clk);
    checks++; if (pops != 5) begin errors++; $display("FAIL beat_timeout got=%0d want=5 pops", pops); end
    checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL beat_five got=%0d want=5", beat_cnt); end
    @(posedge clk); #1;
    dut.beat_cnt = 32'hFFFF_FFFF;
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL beat_wrap_valid got=%b want=1", m_valid); end
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL beat_wrap got=%h want=0", beat_cnt); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_release();
    test_reset_midop();
    test_random();
`ifdef FIFO_RD_STREAM_BEAT_CNT_EN
    test_beat_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 The block SHALL have parameter BUF_DEPTH, fixed at 3, the prefetch buffer depth; it is not user-overridable.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port rst_n_i, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port fifo_rdata_i, input, WIDTH, upstream sync FIFO read data, valid one cycle after an accepted read.
REQ-006 The block SHALL have port fifo_empty_i, input, 1, upstream FIFO empty flag.
REQ-007 The block SHALL have port fifo_rd_en_o, output, 1, upstream FIFO read request.
REQ-008 The block SHALL have port m_data_o, output, WIDTH, downstream stream payload.
REQ-009 The block SHALL have port m_valid_o, output, 1, downstream payload valid.
REQ-010 The block SHALL have port m_ready_i, input, 1, downstream ready.
REQ-011 The block SHALL have port occ_o, output, 2, number of entries in the prefetch buffer (0..3).

Function
REQ-012 The block SHALL convert the FIFO read interface (1-cycle read latency; data zero when not read) into a valid/ready stream.
REQ-013 Internal inflight flag: it SHALL be set to the value of fifo_rd_en_o every cycle, meaning a FIFO word arrives on fifo_rdata_i this cycle.
REQ-014 fifo_rd_en_o SHALL equal !fifo_empty_i && (occ + inflight <= 2), computed only from registers and fifo_empty_i, with no m_ready_i path.
REQ-015 When inflight is 1, the block SHALL capture fifo_rdata_i into the buffer tail at the clock edge.
REQ-016 Pop SHALL be m_valid_o && m_ready_i; on pop, the head SHALL advance with 2-bit pointer wrap modulo 3 (2 -> 0).
REQ-017 The occupancy state machine SHALL have states S0, S1, S2 and S3 (entries held).
REQ-018 S0 -> S1 on push only; Sn -> Sn+1 on push only; Sn -> Sn-1 on pop only; simultaneous push and pop SHALL keep the state.
REQ-019 A push in S3 SHALL be impossible by construction; the bench SHALL assert this never occurs.
REQ-020 m_valid_o SHALL be (state != S0), and m_data_o SHALL be the buffer head entry.
REQ-021 Latency: a word read at cycle N SHALL be presented on m_valid_o/m_data_o at cycle N+2.
REQ-022 With fifo_empty_i = 0 and m_ready_i = 1 sustained, throughput SHALL be one word per cycle.
REQ-023 m_data_o SHALL hold stable while m_valid_o = 1 and m_ready_i = 0.
REQ-024 Ordering SHALL be strict FIFO, with no loss and no duplication.

Reset
REQ-025 On rst_n_i low at a clock edge: state S0, inflight 0, pointers 0, m_valid_o 0, m_data_o 0, occ_o 0, fifo_rd_en_o 0.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words, and the in-flight word SHALL NOT be captured.
REQ-027 Buffer storage contents SHALL NOT require reset.

Configuration
REQ-028 Macro FIFO_RD_STREAM_BEAT_CNT_EN, when defined, SHALL add output beat_cnt_o [31:0].
REQ-029 beat_cnt_o SHALL increment by 1 on each pop, wrap from 0xFFFFFFFF to 0, and reset to 0.
REQ-030 When FIFO_RD_STREAM_BEAT_CNT_EN is undefined, beat_cnt_o and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Reset then fifo_empty_i = 0 with words 0xA0, 0xA1, ... and m_ready_i = 1 SHALL give fifo_rd_en_o = 1 at cycle 0, m_valid_o = 1 with m_data_o = 0xA0 at cycle 2, and then one word per cycle.
REQ-032 m_ready_i = 0 with the FIFO non-empty SHALL give occ_o = 3, fifo_rd_en_o = 0 thereafter, and m_data_o stable at the first word.
REQ-033 Releasing m_ready_i after the full state SHALL drain 3 buffered words in order, then continue at one per cycle with no gap or duplicate.
REQ-034 Random fifo_empty_i and m_ready_i over 10,000 cycles SHALL give output sequence equal to the read sequence, with no push in S3.
REQ-035 rst_n_i low for 1 cycle while occ_o = 2 and inflight = 1 SHALL give, next cycle, m_valid_o = 0 and occ_o = 0, with the in-flight word dropped.
REQ-036 With FIFO_RD_STREAM_BEAT_CNT_EN defined, 5 pops SHALL give beat_cnt_o = 5, and preloading 0xFFFFFFFF then one pop SHALL give beat_cnt_o = 0.
